// File: rtl/multicycle_control.sv
// Multicycle MIPS-subset control FSM: state register plus Moore output decode.
// pcWrite/irWrite in FETCH follow memReady; illegalOp pulses from DECODE.
module multicycle_control (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] opCode,
  input  logic       memReady,
  output logic       pcWrite,
  output logic       pcWriteCond,
  output logic       iorD,
  output logic       memRead,
  output logic       memWrite,
  output logic       memToReg,
  output logic       irWrite,
  output logic       aluSrcA,
  output logic       regWrite,
  output logic       regDest,
  output logic [1:0] pcSource,
  output logic [1:0] aluOp,
  output logic [1:0] aluSrcB,
  output logic [3:0] state,
  output logic       illegalOp
);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEMADDR   = 4'd2,
    MEMREAD   = 4'd3,
    MEMWB     = 4'd4,
    MEMWRITE  = 4'd5,
    EXECUTE   = 4'd6,
    RTYPEDONE = 4'd7,
    BRANCH    = 4'd8,
    JUMP      = 4'd9,
    ADDIEX    = 4'd10,
    ADDIWB    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  state_t st;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) st <= FETCH;
    else begin
      case (st)
        FETCH:     if (memReady) st <= DECODE;
        DECODE: begin
          case (opCode)
            OP_RTYPE:     st <= EXECUTE;
            OP_LW, OP_SW: st <= MEMADDR;
            OP_BEQ:       st <= BRANCH;
            OP_J:         st <= JUMP;
            OP_ADDI:      st <= ADDIEX;
            default:      st <= FETCH;
          endcase
        end
        MEMADDR:   st <= (opCode == OP_LW) ? MEMREAD : MEMWRITE;
        MEMREAD:   if (memReady) st <= MEMWB;
        MEMWRITE:  if (memReady) st <= FETCH;
        EXECUTE:   st <= RTYPEDONE;
        ADDIEX:    st <= ADDIWB;
        default:   st <= FETCH;
      endcase
    end
  end

  // Outputs are forced low while reset is held, even though st already reads FETCH.
  always_comb begin
    pcWrite     = 1'b0;
    pcWriteCond = 1'b0;
    iorD        = 1'b0;
    memRead     = 1'b0;
    memWrite    = 1'b0;
    memToReg    = 1'b0;
    irWrite     = 1'b0;
    aluSrcA     = 1'b0;
    regWrite    = 1'b0;
    regDest     = 1'b0;
    pcSource    = 2'b00;
    aluOp       = 2'b00;
    aluSrcB     = 2'b00;
    illegalOp   = 1'b0;
    if (reset) begin
      case (st)
        FETCH: begin
          memRead = 1'b1;
          aluSrcB = 2'b01;
          irWrite = memReady;
          pcWrite = memReady;
        end
        DECODE: begin
          aluSrcB   = 2'b11;
          illegalOp = !(opCode inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI});
        end
        MEMADDR:   begin aluSrcA = 1'b1; aluSrcB = 2'b10; end
        MEMREAD:   begin memRead = 1'b1; iorD = 1'b1; end
        MEMWB:     begin memToReg = 1'b1; regWrite = 1'b1; end
        MEMWRITE:  begin memWrite = 1'b1; iorD = 1'b1; end
        EXECUTE:   begin aluSrcA = 1'b1; aluOp = 2'b10; end
        RTYPEDONE: begin regDest = 1'b1; regWrite = 1'b1; end
        BRANCH: begin
          aluSrcA     = 1'b1;
          aluOp       = 2'b01;
          pcWriteCond = 1'b1;
          pcSource    = 2'b01;
        end
        JUMP:      begin pcWrite = 1'b1; pcSource = 2'b10; end
        ADDIEX:    begin aluSrcA = 1'b1; aluSrcB = 2'b10; end
        ADDIWB:    regWrite = 1'b1;
        default: ;
      endcase
    end
  end

  assign state = st;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed table-driven bench for multicycle_control plus an async-reset sequence.
module tb_multicycle_control;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] opCode = 6'h00;
  logic       memReady = 1'b1;
  logic       pcWrite, pcWriteCond, iorD, memRead, memWrite, memToReg;
  logic       irWrite, aluSrcA, regWrite, regDest, illegalOp;
  logic [1:0] pcSource, aluOp, aluSrcB;
  logic [3:0] state;

  int errors = 0;
  int checks = 0;

  multicycle_control dut (
    .clock(clock), .reset(reset), .opCode(opCode), .memReady(memReady),
    .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .iorD(iorD),
    .memRead(memRead), .memWrite(memWrite), .memToReg(memToReg),
    .irWrite(irWrite), .aluSrcA(aluSrcA), .regWrite(regWrite),
    .regDest(regDest), .pcSource(pcSource), .aluOp(aluOp),
    .aluSrcB(aluSrcB), .state(state), .illegalOp(illegalOp)
  );

  always #5 clock = ~clock;

  // {pcWrite,pcWriteCond,iorD,memRead,memWrite,memToReg,irWrite,aluSrcA,regWrite,regDest,pcSource,aluOp,aluSrcB,illegalOp}
  logic [16:0] outs;
  assign outs = {pcWrite, pcWriteCond, iorD, memRead, memWrite, memToReg, irWrite,
                 aluSrcA, regWrite, regDest, pcSource, aluOp, aluSrcB, illegalOp};

  localparam logic [16:0] O_ZERO = 17'b0000000000_00_00_00_0;
  localparam logic [16:0] O_F1   = 17'b1001001000_00_00_01_0;
  localparam logic [16:0] O_F0   = 17'b0001000000_00_00_01_0;
  localparam logic [16:0] O_DEC  = 17'b0000000000_00_00_11_0;
  localparam logic [16:0] O_DILL = 17'b0000000000_00_00_11_1;
  localparam logic [16:0] O_MA   = 17'b0000000100_00_00_10_0;
  localparam logic [16:0] O_MRD  = 17'b0011000000_00_00_00_0;
  localparam logic [16:0] O_MWB  = 17'b0000010010_00_00_00_0;
  localparam logic [16:0] O_MW   = 17'b0010100000_00_00_00_0;
  localparam logic [16:0] O_EXE  = 17'b0000000100_00_10_00_0;
  localparam logic [16:0] O_RTD  = 17'b0000000011_00_00_00_0;
  localparam logic [16:0] O_BR   = 17'b0100000100_01_01_00_0;
  localparam logic [16:0] O_JMP  = 17'b1000000000_10_00_00_0;
  localparam logic [16:0] O_AIEX = 17'b0000000100_00_00_10_0;
  localparam logic [16:0] O_AIWB = 17'b0000000010_00_00_00_0;

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic        rdy;
    logic [3:0]  exp_st;
    logic [16:0] exp_out;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    vecs = '{
      '{1'b0, 6'h00, 1'b1, 4'd0,  O_ZERO},
      '{1'b1, 6'h00, 1'b1, 4'd0,  O_F1},
      '{1'b1, 6'h00, 1'b1, 4'd1,  O_DEC},
      '{1'b1, 6'h00, 1'b1, 4'd6,  O_EXE},
      '{1'b1, 6'h00, 1'b1, 4'd7,  O_RTD},
      '{1'b1, 6'h23, 1'b1, 4'd0,  O_F1},
      '{1'b1, 6'h23, 1'b1, 4'd1,  O_DEC},
      '{1'b1, 6'h23, 1'b1, 4'd2,  O_MA},
      '{1'b1, 6'h23, 1'b0, 4'd3,  O_MRD},
      '{1'b1, 6'h23, 1'b0, 4'd3,  O_MRD},
      '{1'b1, 6'h23, 1'b1, 4'd3,  O_MRD},
      '{1'b1, 6'h23, 1'b1, 4'd4,  O_MWB},
      '{1'b1, 6'h2B, 1'b0, 4'd0,  O_F0},
      '{1'b1, 6'h2B, 1'b1, 4'd0,  O_F1},
      '{1'b1, 6'h2B, 1'b1, 4'd1,  O_DEC},
      '{1'b1, 6'h2B, 1'b1, 4'd2,  O_MA},
      '{1'b1, 6'h00, 1'b0, 4'd5,  O_MW},
      '{1'b1, 6'h00, 1'b1, 4'd5,  O_MW},
      '{1'b1, 6'h04, 1'b1, 4'd0,  O_F1},
      '{1'b1, 6'h04, 1'b1, 4'd1,  O_DEC},
      '{1'b1, 6'h04, 1'b1, 4'd8,  O_BR},
      '{1'b1, 6'h02, 1'b1, 4'd0,  O_F1},
      '{1'b1, 6'h02, 1'b1, 4'd1,  O_DEC},
      '{1'b1, 6'h02, 1'b1, 4'd9,  O_JMP},
      '{1'b1, 6'h08, 1'b1, 4'd0,  O_F1},
      '{1'b1, 6'h08, 1'b1, 4'd1,  O_DEC},
      '{1'b1, 6'h08, 1'b1, 4'd10, O_AIEX},
      '{1'b1, 6'h08, 1'b1, 4'd11, O_AIWB},
      '{1'b1, 6'h3F, 1'b1, 4'd0,  O_F1},
      '{1'b1, 6'h3F, 1'b1, 4'd1,  O_DILL},
      '{1'b1, 6'h00, 1'b1, 4'd0,  O_F1},
      '{1'b1, 6'h00, 1'b1, 4'd1,  O_DEC}
    };

    foreach (vecs[i]) begin
      reset    = vecs[i].rst;
      opCode   = vecs[i].op;
      memReady = vecs[i].rdy;
      @(negedge clock);
      chk($sformatf("vec%0d state", i), 32'(state), 32'(vecs[i].exp_st));
      chk($sformatf("vec%0d outs", i), 32'(outs), 32'(vecs[i].exp_out));
      @(posedge clock);
      #1;
    end

    // Walk into MEMWRITE and stall it there, then pull reset between edges.
    opCode = 6'h2B;
    memReady = 1'b1;
    begin
      int n;
      n = 0;
      while (state != 4'd5 && n < 10) begin
        @(posedge clock);
        #1;
        n++;
      end
      chk("reach MEMWRITE", 32'(state), 32'd5);
    end
    memReady = 1'b0;
    @(negedge clock);
    chk("memwrite stall state", 32'(state), 32'd5);
    chk("memwrite stall outs", 32'(outs), 32'(O_MW));
    #2 reset = 1'b0;
    #1;
    chk("async reset state", 32'(state), 32'd0);
    chk("async reset outs", 32'(outs), 32'(O_ZERO));
    @(posedge clock);
    #1;
    chk("reset held state", 32'(state), 32'd0);
    chk("reset held outs", 32'(outs), 32'(O_ZERO));
    reset = 1'b1;
    memReady = 1'b1;
    opCode = 6'h00;
    @(negedge clock);
    chk("release fetch state", 32'(state), 32'd0);
    chk("release fetch outs", 32'(outs), 32'(O_F1));
    @(posedge clock);
    #1;
    @(negedge clock);
    chk("release decode state", 32'(state), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
